mccoy_host: RTL and testbench

- Host-side driver for the McCoy core's 8-bit pad interface: the other end of the core's io_in/io_out link.
- Generates the core clock and core reset, and serves 6-bit instructions from a loadable program memory indexed by the core PC.
- Demultiplexes the core's time-shared io_out into PC (high phase) and x8 (low phase), and reports each executed step.
- Used on the FPGA/bench side to run programs on the taped-out core.

---
 rtl/mccoy_pkg.sv | 22 ++
 rtl/mccoy_prog_mem.sv | 27 ++
 rtl/mccoy_host.sv | 236 +++++++++++++++++++++++
 tb/tb_mccoy_host.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mccoy_pkg.sv
// mccoy_pkg: shared types and constants for the McCoy host driver.
// Pad bit positions, widths and the host FSM state encoding.
package mccoy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        HIGH,
        LOW,
        DONE
    } state_e;

    localparam int CORE_CLK_BIT = 0;
    localparam int CORE_RST_BIT = 1;
    localparam int INSTR_LSB    = 2;
    localparam int INSTR_MSB    = 5;
    localparam int NIB_W        = INSTR_MSB - INSTR_LSB + 1;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 6;

endpackage

// File: rtl/mccoy_prog_mem.sv
// mccoy_prog_mem: 256x6 program store, one write port and one
// registered read port. Contents survive host reset.
module mccoy_prog_mem
    import mccoy_pkg::*;
(
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [PC_W-1:0]    waddr_i,
    input  logic [INSTR_W-1:0] wdata_i,
    input  logic               re_i,
    input  logic [PC_W-1:0]    raddr_i,
    output logic [INSTR_W-1:0] rdata_o
);

    logic [INSTR_W-1:0] mem_q [2**PC_W];

    // Write port and registered read port; no reset on the array.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/mccoy_host.sv
// mccoy_host: drives core clock/reset, serves instructions by PC and
// demuxes PC/x8. Optional MCCOY_HOST_TRACE_STALL_EN: trace handshake stalls core.
module mccoy_host
    import mccoy_pkg::*;
#(
    parameter int HALF_PERIOD = 2,
    parameter int RST_CYCLES  = 2,
    parameter int STEP_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [7:0]        ld_addr,
    input  logic [5:0]        ld_data,
    input  logic              start,
    input  logic [STEP_W-1:0] run_steps,
    output logic              busy,
    output logic              done,
    output logic              halted,
    output logic [7:0]        core_io_in,
    input  logic [7:0]        core_io_out,
    output logic [7:0]        pc_q,
    output logic [7:0]        x8_q,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [STEP_W-1:0] step_count
);

    localparam int CW = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;
    localparam int RW = (RST_CYCLES > 2) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF_PERIOD - 1);
    localparam logic [RW-1:0] RCNT_LAST = RW'(RST_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_MAX = '1;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]     rcnt_q, rcnt_d;
    logic              ck_q, ck_d;
    logic              first_q, first_d;
    logic [7:0]        prev_pc_q, prev_pc_d;
    logic [7:0]        pc_d, x8_d;
    logic [NIB_W-1:0]  instr_q, instr_d;
    logic              tv_q, tv_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [STEP_W-1:0] limit_q, limit_d;
    logic              halted_q, halted_d;
    logic              done_q, done_d;

    logic               phase_end;
    logic               mem_we;
    logic               mem_re;
    logic [INSTR_W-1:0] rdata;
    logic [STEP_W-1:0]  step_inc;
    logic               halt_hit;
    logic               limit_hit;
    logic               step_done;
    logic               unused_ok;

    assign ld_ready = (state_q == IDLE) || (state_q == DONE);
    assign busy = (state_q == RST) || (state_q == HIGH)
               || (state_q == LOW);
    assign done = done_q;
    assign halted = halted_q;
    assign trace_valid = tv_q;
    assign step_count = step_q;
    assign mem_we = ld_valid && ld_ready;
    assign unused_ok = ^{rdata[1:0], trace_ready};

    assign phase_end = (cnt_q == CNT_LAST);
    assign step_inc = (step_q == STEP_MAX) ? step_q : step_q + 1'b1;
    assign halt_hit = !first_q && (pc_q == prev_pc_q);
    assign limit_hit = (limit_q != '0) && (step_inc == limit_q);

    mccoy_prog_mem u_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (ld_addr),
        .wdata_i (ld_data),
        .re_i    (mem_re),
        .raddr_i (core_io_out),
        .rdata_o (rdata)
    );

    // Pad outputs decoded from the registered state.
    always_comb begin
        core_io_in = '0;
        core_io_in[CORE_CLK_BIT] = (state_q == HIGH)
                                || ((state_q == RST) && ck_q);
        core_io_in[CORE_RST_BIT] = (state_q == RST);
        if ((state_q == HIGH) || (state_q == LOW)) begin
            core_io_in[INSTR_MSB:INSTR_LSB] = instr_q;
        end
    end

    // Next-state and datapath updates for the run sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rcnt_d    = rcnt_q;
        ck_d      = ck_q;
        first_d   = first_q;
        prev_pc_d = prev_pc_q;
        pc_d      = pc_q;
        x8_d      = x8_q;
        instr_d   = instr_q;
`ifdef MCCOY_HOST_TRACE_STALL_EN
        tv_d      = tv_q;
`else
        tv_d      = 1'b0;
`endif
        step_d    = step_q;
        limit_d   = limit_q;
        halted_d  = halted_q;
        done_d    = done_q;
        mem_re    = 1'b0;
        step_done = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RST;
                    cnt_d    = '0;
                    rcnt_d   = '0;
                    ck_d     = 1'b1;
                    first_d  = 1'b1;
                    instr_d  = '0;
                    tv_d     = 1'b0;
                    step_d   = '0;
                    halted_d = 1'b0;
                    done_d   = 1'b0;
                    limit_d  = run_steps;
                end
            end
            RST: begin
                cnt_d = cnt_q + 1'b1;
                if (phase_end) begin
                    cnt_d = '0;
                    ck_d  = ~ck_q;
                    if (!ck_q) begin
                        rcnt_d = rcnt_q + 1'b1;
                        if (rcnt_q == RCNT_LAST) begin
                            state_d = HIGH;
                        end
                    end
                end
            end
            HIGH: begin
                cnt_d = cnt_q + 1'b1;
                if (phase_end) begin
                    cnt_d     = '0;
                    pc_d      = core_io_out;
                    prev_pc_d = pc_q;
                    mem_re    = 1'b1;
                    state_d   = LOW;
                end
            end
            LOW: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '0) begin
                    instr_d = rdata[INSTR_MSB:INSTR_LSB];
                end
                if (phase_end) begin
`ifdef MCCOY_HOST_TRACE_STALL_EN
                    cnt_d = cnt_q;
                    if (!tv_q) begin
                        x8_d = core_io_out;
                        tv_d = 1'b1;
                    end else if (trace_ready) begin
                        tv_d      = 1'b0;
                        step_done = 1'b1;
                    end
`else
                    x8_d      = core_io_out;
                    tv_d      = 1'b1;
                    step_done = 1'b1;
`endif
                end
                if (step_done) begin
                    cnt_d   = '0;
                    step_d  = step_inc;
                    first_d = 1'b0;
                    if (halt_hit) begin
                        halted_d = 1'b1;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else if (limit_hit) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = HIGH;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rcnt_q    <= '0;
            ck_q      <= 1'b0;
            first_q   <= 1'b0;
            prev_pc_q <= '0;
            pc_q      <= '0;
            x8_q      <= '0;
            instr_q   <= '0;
            tv_q      <= 1'b0;
            step_q    <= '0;
            limit_q   <= '0;
            halted_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rcnt_q    <= rcnt_d;
            ck_q      <= ck_d;
            first_q   <= first_d;
            prev_pc_q <= prev_pc_d;
            pc_q      <= pc_d;
            x8_q      <= x8_d;
            instr_q   <= instr_d;
            tv_q      <= tv_d;
            step_q    <= step_d;
            limit_q   <= limit_d;
            halted_q  <= halted_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_mccoy_host.sv
// tb_mccoy_host: behavioural core + scoreboard for mccoy_host.
// Random programs/PC streams; directed load, limit, halt, demux, reset.
module tb_mccoy_host;

    localparam int HP = 2;
    localparam int RC = 2;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          ld_valid;
    logic          ld_ready;
    logic [7:0]    ld_addr;
    logic [5:0]    ld_data;
    logic          start;
    logic [SW-1:0] run_steps;
    logic          busy;
    logic          done;
    logic          halted;
    logic [7:0]    core_io_in;
    logic [7:0]    core_io_out;
    logic [7:0]    pc_q;
    logic [7:0]    x8_q;
    logic          trace_valid;
    logic          trace_ready;
    logic [SW-1:0] step_count;

    always #5 clk = ~clk;

    mccoy_host #(.HALF_PERIOD(HP), .RST_CYCLES(RC), .STEP_W(SW)) dut (
        .clk         (clk),
        .reset       (reset),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .start       (start),
        .run_steps   (run_steps),
        .busy        (busy),
        .done        (done),
        .halted      (halted),
        .core_io_in  (core_io_in),
        .core_io_out (core_io_out),
        .pc_q        (pc_q),
        .x8_q        (x8_q),
        .trace_valid (trace_valid),
        .trace_ready (trace_ready),
        .step_count  (step_count)
    );

    // behavioural core: PC while its clock is high, x8 while low
    logic [7:0] m_pc = 8'h00;
    logic [7:0] m_x8 = 8'h00;
    assign core_io_out = core_io_in[0] ? m_pc : m_x8;

    int n_vec = 0;
    int n_err = 0;

    logic [5:0] mem_m [256];
    logic [7:0] seq [4];
    logic [7:0] q_pc [$];
    logic [7:0] q_x8 [$];
    logic [3:0] instr_log [16];
    logic [7:0] pc_log [16];
    logic [3:0] exp_i [4] = '{4'hF, 4'h5, 4'h2, 4'h8};

    int   mode = 0;
    int   sidx = 0;
    int   steps = 0;
    int   lim_m = 0;
    int   rst_cyc = 0;
    int   stall_cyc = 0;
    int   hold = 0;
    bit   hold_arm = 0;
    bit   chk_en = 0;
    bit   term_seen = 0;
    bit   exp_term = 0;
    bit   exp_halt = 0;
    bit   pend = 0;
    bit   wait_q = 0;
    logic prev_ck = 1'b0;
    logic [7:0] prev_pc_m = 8'h00;
    logic [7:0] last_pc = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic rec_check();
        logic [7:0] ep;
        logic [7:0] ex;
        chk("trace_after_done", term_seen, 0);
        if (q_pc.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL trace_no_step: record with no core step");
            return;
        end
        ep = q_pc.pop_front();
        ex = q_x8.pop_front();
        chk("pc_q", pc_q, ep);
        chk("x8_q", x8_q, ex);
        if (steps < 16) pc_log[steps] = pc_q;
        steps++;
        exp_halt = (steps > 1) && (ep == prev_pc_m);
        exp_term = exp_halt || ((lim_m != 0) && (steps == lim_m));
        prev_pc_m = ep;
    endtask

    task automatic post_check();
        chk("step_count", step_count, steps);
        chk("done", done, exp_term);
        chk("busy", busy, !exp_term);
        chk("halted", halted, exp_halt);
        if (exp_term) term_seen = 1;
    endtask

    // one compare process: checks DUT vs model, then advances the core model
    always @(negedge clk) begin
        logic ck;
        logic crst;
        ck = core_io_in[0];
        crst = core_io_in[1];
        if (chk_en) begin
            chk("ld_ready_vs_busy", ld_ready, !busy);
            chk("io_in_7_6", core_io_in[7:6], 0);
            if (crst) rst_cyc++;
            if (busy && !crst && !ck && !prev_ck) begin
                chk("instr", core_io_in[5:2], mem_m[last_pc][5:2]);
                if (steps < 16) instr_log[steps] = core_io_in[5:2];
            end
`ifdef MCCOY_HOST_TRACE_STALL_EN
            if (pend) begin
                post_check();
                pend = 0;
            end
            if (wait_q) chk("trace_held", trace_valid, 1);
            if (trace_valid && !trace_ready) begin
                chk("stall_core_clk", ck, 0);
                chk("stall_count", step_count, steps);
                stall_cyc++;
            end
            wait_q = trace_valid && !trace_ready;
            if (trace_valid && trace_ready) begin
                rec_check();
                pend = 1;
            end
`else
            if (trace_valid) begin
                rec_check();
                post_check();
            end
`endif
        end
        if (prev_ck && !ck) begin
            if (crst) begin
                m_pc = (mode == 2) ? 8'hA5 : 8'h00;
                sidx = 1;
            end else begin
                q_pc.push_back(m_pc);
                last_pc = m_pc;
                m_x8 = (mode == 2) ? 8'h3C : 8'($urandom);
                q_x8.push_back(m_x8);
                case (mode)
                    0: m_pc = m_pc + 8'd1;
                    1: begin
                        m_pc = seq[sidx];
                        if (sidx < 3) sidx++;
                    end
                    3: m_pc = 8'($urandom_range(0, 15));
                    default: m_pc = m_pc;
                endcase
            end
        end
        prev_ck = ck;
        if (hold_arm) begin
            trace_ready = 1'b0;
            if (trace_valid) begin
                hold_arm = 0;
                hold = 9;
            end
        end else if (hold > 0) begin
            trace_ready = 1'b0;
            hold--;
        end else begin
            trace_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic load(input logic [7:0] a, input logic [5:0] d);
        ld_valid = 1'b1;
        ld_addr = a;
        ld_data = d;
        if (ld_ready) mem_m[a] = d;
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic begin_run(input int md, input int lim);
        mode = md;
        lim_m = lim;
        steps = 0;
        term_seen = 0;
        exp_term = 0;
        exp_halt = 0;
        pend = 0;
        wait_q = 0;
        rst_cyc = 0;
        q_pc.delete();
        q_x8.delete();
        m_pc = (md == 2) ? 8'hA5 : 8'h00;
        m_x8 = (md == 2) ? 8'h3C : 8'h00;
        run_steps = SW'(lim);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_steps = SW'($urandom);
    endtask

    task automatic run(input int md, input int lim, input int budget);
        int cyc;
        begin_run(md, lim);
        cyc = 0;
        while (!done && cyc < budget) begin
            ld_valid = $urandom_range(0, 1);
            ld_addr = 8'($urandom);
            ld_data = 6'($urandom);
            if (ld_valid && ld_ready) mem_m[ld_addr] = ld_data;
            start = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            cyc++;
        end
        ld_valid = 1'b0;
        start = 1'b0;
        chk("run_done", done, 1);
        repeat (3) @(negedge clk);
        chk("run_terminated", term_seen, 1);
        chk("rst_cycles", rst_cyc, 2 * RC * HP);
        chk("busy_after_done", busy, 0);
    endtask

    initial begin
        int lc;
        int cyc;
        reset = 1'b0;
        ld_valid = 1'b0;
        ld_addr = 8'h00;
        ld_data = 6'h00;
        start = 1'b0;
        run_steps = '0;
        trace_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_halted", halted, 0);
        chk("rst_trace_valid", trace_valid, 0);
        chk("rst_core_io_in", core_io_in, 0);
        chk("rst_pc_q", pc_q, 0);
        chk("rst_x8_q", x8_q, 0);
        chk("rst_step_count", step_count, 0);
        reset = 1'b1;
        chk_en = 1;
        @(negedge clk);

        for (int i = 0; i < 256; i++) load(8'(i), 6'($urandom));
        load(8'd0, 6'h3C);
        load(8'd1, 6'h14);
        load(8'd2, 6'h08);
        load(8'd3, 6'h20);

        // program readback through the pad
        run(0, 4, 300);
        for (int i = 0; i < 4; i++) begin
            chk("load_instr", instr_log[i], exp_i[i]);
            chk("load_pc", pc_log[i], i);
        end

        // step limit
        run(0, 5, 300);
        chk("lim_steps", steps, 5);
        chk("lim_step_count", step_count, 5);
        chk("lim_halted", halted, 0);
        chk("lim_done", done, 1);

        // halt on PC self-loop
        seq = '{8'd0, 8'd1, 8'd2, 8'd2};
        run(1, 0, 300);
        chk("halt_halted", halted, 1);
        chk("halt_done", done, 1);
        chk("halt_pc_q", pc_q, 8'h02);
        chk("halt_step_count", step_count, 4);

        // io_out demux
        run(2, 0, 300);
        chk("demux_pc_q", pc_q, 8'hA5);
        chk("demux_x8_q", x8_q, 8'h3C);
        chk("demux_step_count", step_count, 2);

        // reset in the 2nd cycle of LOW, then restart
        begin_run(0, 0);
        lc = 0;
        cyc = 0;
        while (cyc < 300) begin
            lc = (busy && !core_io_in[1] && !core_io_in[0]) ? lc + 1 : 0;
            if (lc == 2 && steps >= 2) break;
            @(negedge clk);
            cyc++;
        end
        chk("mid_reached_low", lc, 2);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_core_io_in", core_io_in, 0);
        chk("mid_ld_ready", ld_ready, 1);
        chk("mid_busy", busy, 0);
        chk("mid_trace_valid", trace_valid, 0);
        chk("mid_step_count", step_count, 0);
        reset = 1'b1;
        @(negedge clk);
        run(0, 3, 300);
        chk("mid_restart_steps", step_count, 3);

`ifdef MCCOY_HOST_TRACE_STALL_EN
        // consumer holds off the first record
        stall_cyc = 0;
        hold_arm = 1;
        run(0, 3, 400);
        chk("stall_cycles_ge10", stall_cyc >= 10, 1);
        chk("stall_step_count", step_count, 3);
`endif

        // random programs, PC streams and limits
        for (int r = 0; r < 25; r++) begin
            repeat ($urandom_range(0, 4)) load(8'($urandom_range(0, 15)), 6'($urandom));
            if (r % 3 == 0) run(0, $urandom_range(1, 12), 400);
            else run(3, $urandom_range(1, 20), 400);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
